// File: rtl/seq_det_param.sv
// Serial pattern detector with runtime-loadable pattern and overlap mode,
// registered match pulse and a saturating, clearable match counter.
module seq_det_param #(
  parameter int             N       = 6,
  parameter logic [N-1:0]   PATTERN = 6'b101011,
  parameter bit             OVERLAP = 1'b0,
  parameter int             CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in,
  input  logic             in_valid,
  input  logic             cfg_load,
  input  logic [N-1:0]     cfg_pattern,
  input  logic             cfg_overlap,
  input  logic             cnt_clr,
  output logic             z,
  output logic [CNT_W-1:0] match_cnt,
  output logic             cnt_sat,
  output logic             state
);

  // in_valid qualifies in on a rising edge; there is no back-pressure, so a
  // bit presented with in_valid=1 is always consumed unless cfg_load or rst
  // is also high on that edge.

  typedef enum logic {
    FILL  = 1'b0,
    ARMED = 1'b1
  } state_t;

  localparam int               FW        = $clog2(N + 1);
  localparam logic [FW-1:0]    FILL_FULL = FW'(N);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  state_t         cur_state;
  logic [N-1:0]   hist;
  logic [N-1:0]   act_pat;
  logic           act_ovl;
  logic [FW-1:0]  fill;

  logic [N-1:0]   hist_next;
  logic [FW-1:0]  fill_inc;
  logic           match;

  always_comb begin
    hist_next = {hist[N-2:0], in};
    fill_inc  = (fill == FILL_FULL) ? FILL_FULL : fill + FW'(1);
    match     = in_valid && !cfg_load && (hist_next == act_pat) &&
                (fill_inc == FILL_FULL);
  end

  // Detector FSM: state mirrors whether the fill counter has reached N.
  always_ff @(posedge clk) begin
    if (rst) begin
      cur_state <= FILL;
      hist      <= '0;
      fill      <= '0;
      act_pat   <= PATTERN;
      act_ovl   <= OVERLAP;
      z         <= 1'b0;
    end else begin
      z <= 1'b0;
      if (cfg_load) begin
        act_pat   <= cfg_pattern;
        act_ovl   <= cfg_overlap;
        hist      <= '0;
        fill      <= '0;
        cur_state <= FILL;
      end else if (in_valid) begin
        hist <= hist_next;
        if (match) begin
          z <= 1'b1;
          // Non-overlapping mode needs N fresh bits before the next match.
          if (act_ovl) begin
            fill      <= FILL_FULL;
            cur_state <= ARMED;
          end else begin
            fill      <= '0;
            cur_state <= FILL;
          end
        end else begin
          fill      <= fill_inc;
          cur_state <= (fill_inc == FILL_FULL) ? ARMED : FILL;
        end
      end
    end
  end

  // Clear wins over a same-edge match; cfg_load never touches the counter.
  always_ff @(posedge clk) begin
    if (rst || cnt_clr) begin
      match_cnt <= '0;
      cnt_sat   <= 1'b0;
    end else if (match && (match_cnt != CNT_MAX)) begin
      match_cnt <= match_cnt + CNT_W'(1);
      if (match_cnt == CNT_MAX - CNT_W'(1)) begin
        cnt_sat <= 1'b1;
      end
    end
  end

  assign state = cur_state;

endmodule

// File: tb/tb_seq_det_param.sv
// Bench for seq_det_param: three instances (default, N=4, N=2/CNT_W=2) checked
// each cycle against a bit-queue reference model, plus directed scenarios.
module tb_seq_det_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [2:0] rst_v, in_v, val_v, ld_v, ovl_v, clr_v;
  logic [5:0] pat0;
  logic [3:0] pat1;
  logic [1:0] pat2;
  logic [2:0] z_v, sat_v, st_v;
  logic [7:0] cnt0, cnt1;
  logic [1:0] cnt2;

  seq_det_param dut0 (
    .clk(clk), .rst(rst_v[0]), .in(in_v[0]), .in_valid(val_v[0]),
    .cfg_load(ld_v[0]), .cfg_pattern(pat0), .cfg_overlap(ovl_v[0]),
    .cnt_clr(clr_v[0]), .z(z_v[0]), .match_cnt(cnt0), .cnt_sat(sat_v[0]),
    .state(st_v[0])
  );

  seq_det_param #(.N(4), .PATTERN(4'b1011), .OVERLAP(1'b0), .CNT_W(8)) dut1 (
    .clk(clk), .rst(rst_v[1]), .in(in_v[1]), .in_valid(val_v[1]),
    .cfg_load(ld_v[1]), .cfg_pattern(pat1), .cfg_overlap(ovl_v[1]),
    .cnt_clr(clr_v[1]), .z(z_v[1]), .match_cnt(cnt1), .cnt_sat(sat_v[1]),
    .state(st_v[1])
  );

  seq_det_param #(.N(2), .PATTERN(2'b11), .OVERLAP(1'b1), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst_v[2]), .in(in_v[2]), .in_valid(val_v[2]),
    .cfg_load(ld_v[2]), .cfg_pattern(pat2), .cfg_overlap(ovl_v[2]),
    .cnt_clr(clr_v[2]), .z(z_v[2]), .match_cnt(cnt2), .cnt_sat(sat_v[2]),
    .state(st_v[2])
  );

  // ---------------- reference model ----------------
  int          m_n[3];
  int          m_max[3];
  logic [31:0] m_def_pat[3];
  bit          m_def_ovl[3];
  bit          hq[3][$];       // bits seen since last restart, oldest first
  logic [31:0] m_pat[3];
  bit          m_ovl[3];
  bit          m_z[3];
  int          m_cnt[3];
  bit          m_sat[3];

  int checks = 0;
  int errors = 0;
  int zc[3];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] cur_pat(int k);
    case (k)
      0: return 32'(pat0);
      1: return 32'(pat1);
      default: return 32'(pat2);
    endcase
  endfunction

  function automatic logic [31:0] dut_cnt(int k);
    case (k)
      0: return 32'(cnt0);
      1: return 32'(cnt1);
      default: return 32'(cnt2);
    endcase
  endfunction

  task automatic model_edge(int k);
    bit hit;
    int n;
    n   = m_n[k];
    hit = 1'b0;
    if (rst_v[k]) begin
      hq[k].delete();
      m_pat[k] = m_def_pat[k];
      m_ovl[k] = m_def_ovl[k];
      m_z[k]   = 1'b0;
      m_cnt[k] = 0;
      m_sat[k] = 1'b0;
      return;
    end
    m_z[k] = 1'b0;
    if (ld_v[k]) begin
      m_pat[k] = cur_pat(k);
      m_ovl[k] = ovl_v[k];
      hq[k].delete();
    end else if (val_v[k]) begin
      hq[k].push_back(in_v[k]);
      if (hq[k].size() > n) void'(hq[k].pop_front());
      if (hq[k].size() == n) begin
        hit = 1'b1;
        for (int i = 0; i < n; i++)
          if (hq[k][i] != m_pat[k][n-1-i]) hit = 1'b0;
      end
      if (hit) begin
        m_z[k] = 1'b1;
        if (!m_ovl[k]) hq[k].delete();
      end
    end
    if (clr_v[k]) begin
      m_cnt[k] = 0;
      m_sat[k] = 1'b0;
    end else if (hit && m_cnt[k] < m_max[k]) begin
      m_cnt[k]++;
      if (m_cnt[k] == m_max[k]) m_sat[k] = 1'b1;
    end
  endtask

  // One clock: model follows the edge, outputs sampled 1 time unit later.
  task automatic cycle();
    @(posedge clk);
    for (int k = 0; k < 3; k++) model_edge(k);
    #1;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("z%0d", k), 32'(z_v[k]), 32'(m_z[k]));
      check($sformatf("cnt%0d", k), dut_cnt(k), 32'(m_cnt[k]));
      check($sformatf("sat%0d", k), 32'(sat_v[k]), 32'(m_sat[k]));
      check($sformatf("state%0d", k), 32'(st_v[k]), 32'(hq[k].size() == m_n[k]));
      if (z_v[k]) zc[k]++;
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle_all();
    rst_v = '0; in_v = '0; val_v = '0; ld_v = '0; ovl_v = '0; clr_v = '0;
    pat0 = '0; pat1 = '0; pat2 = '0;
  endtask

  task automatic step(int d, bit r, bit b, bit v, bit ld, logic [31:0] p, bit o, bit c);
    idle_all();
    rst_v[d] = r; in_v[d] = b; val_v[d] = v; ld_v[d] = ld; ovl_v[d] = o; clr_v[d] = c;
    case (d)
      0: pat0 = p[5:0];
      1: pat1 = p[3:0];
      default: pat2 = p[1:0];
    endcase
    cycle();
  endtask

  task automatic send(int d, bit b);
    step(d, 1'b0, b, 1'b1, 1'b0, 0, 1'b0, 1'b0);
  endtask

  task automatic send_str(int d, string s);
    for (int i = 0; i < s.len(); i++) send(d, s[i] == "1");
  endtask

  task automatic do_rst(int d);
    step(d, 1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0);
  endtask

  task automatic load(int d, logic [31:0] p, bit o);
    step(d, 1'b0, 1'b1, 1'b1, 1'b1, p, o, 1'b0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    m_n       = '{6, 4, 2};
    m_max     = '{255, 255, 3};
    m_def_pat = '{32'b101011, 32'b1011, 32'b11};
    m_def_ovl = '{1'b0, 1'b0, 1'b1};
    for (int k = 0; k < 3; k++) begin
      m_pat[k] = m_def_pat[k]; m_ovl[k] = m_def_ovl[k];
      m_z[k] = 1'b0; m_cnt[k] = 0; m_sat[k] = 1'b0; zc[k] = 0;
    end
    idle_all();
    rst_v = 3'b111;
    cycle();
    check("rst_cnt0", dut_cnt(0), 0);
    check("rst_z0", 32'(z_v[0]), 0);

    // Default pattern, two back-to-back non-overlapping matches.
    zc[0] = 0;
    send_str(0, "101011101011");
    check("seq12_pulses", zc[0], 2);
    check("seq12_cnt", dut_cnt(0), 2);

    // Runtime pattern 1011, overlap vs non-overlap.
    do_rst(1);
    load(1, 32'b1011, 1'b1);
    zc[1] = 0;
    send_str(1, "1011011");
    check("ovl_pulses", zc[1], 2);
    check("ovl_cnt", dut_cnt(1), 2);
    do_rst(1);
    load(1, 32'b1011, 1'b0);
    zc[1] = 0;
    send_str(1, "1011011");
    check("novl_pulses", zc[1], 1);
    check("novl_cnt", dut_cnt(1), 1);

    // in_valid gap inside a pattern.
    do_rst(0);
    zc[0] = 0;
    send_str(0, "101");
    for (int i = 0; i < 3; i++) begin
      step(0, 1'b0, 1'($urandom_range(0, 1)), 1'b0, 1'b0, 0, 1'b0, 1'b0);
      check("gap_z", 32'(z_v[0]), 0);
    end
    send_str(0, "011");
    check("gap_pulses", zc[0], 1);

    // cfg_load discards partial history and its own input bit.
    do_rst(0);
    zc[0] = 0;
    send_str(0, "10101");
    load(0, 32'b101011, 1'b0);
    send(0, 1'b1);
    check("load_nomatch", zc[0], 0);
    send_str(0, "101011");
    check("load_then_match", zc[0], 1);

    // Saturating counter with overlap pattern 11.
    do_rst(2);
    load(2, 32'b11, 1'b1);
    send(2, 1'b1);
    send(2, 1'b1);
    check("sat_cnt1", dut_cnt(2), 1);
    send(2, 1'b1);
    check("sat_cnt2", dut_cnt(2), 2);
    check("sat_flag2", 32'(sat_v[2]), 0);
    send(2, 1'b1);
    check("sat_cnt3", dut_cnt(2), 3);
    check("sat_flag3", 32'(sat_v[2]), 1);
    send(2, 1'b1);
    check("sat_hold", dut_cnt(2), 3);
    step(2, 1'b0, 1'b1, 1'b1, 1'b0, 0, 1'b0, 1'b1);
    check("clr_z", 32'(z_v[2]), 1);
    check("clr_cnt", dut_cnt(2), 0);
    check("clr_sat", 32'(sat_v[2]), 0);

    // Reset mid-sequence discards the partial match.
    do_rst(0);
    zc[0] = 0;
    send_str(0, "10101");
    do_rst(0);
    send(0, 1'b1);
    send_str(0, "0101");
    check("rst_mid_none", zc[0], 0);
    send(0, 1'b1);
    check("rst_mid_z", 32'(z_v[0]), 1);
    check("rst_mid_pulses", zc[0], 1);

    // Reset wins over load, clear and valid on the same edge.
    step(0, 1'b1, 1'b1, 1'b1, 1'b1, 32'b111111, 1'b1, 1'b1);
    check("rst_prio_cnt", dut_cnt(0), 0);

    // Randomized traffic on all three instances.
    for (int t = 0; t < 3000; t++) begin
      int d;
      bit r, v, ld, c;
      d  = $urandom_range(0, 2);
      r  = ($urandom_range(0, 199) == 0);
      ld = ($urandom_range(0, 49) == 0);
      c  = ($urandom_range(0, 59) == 0);
      v  = ($urandom_range(0, 9) < 8);
      step(d, r, 1'($urandom_range(0, 1)), v, ld,
           $urandom & ((32'd1 << m_n[d]) - 1), 1'($urandom_range(0, 1)), c);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
